io_mmio_unit: RTL and testbench

- Memory-mapped I/O target for the RISC-V pipeline, sitting directly downstream of the memory-control decode stage.
- Consumes the per-byte I/O write enables (io_trans) and the I/O read strobe (io_recv) for addresses with A[31:28]=4'b1000.
- Buffers UART traffic in TX/RX FIFOs, keeps cycle and retired-instruction counters, and returns registered read data to the writeback mux.

---
 rtl/io_mmio_unit_if.sv | 26 ++
 rtl/io_mmio_unit.sv | 149 ++++++++++++++
 tb/tb_io_mmio_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_mmio_unit_if.sv
// Bus between memory control / UART pins and the MMIO target.
// The master modport is the driving side (pipeline, UART), the slave modport is the unit.
interface io_mmio_unit_if;
    logic [3:0]  io_trans;
    logic        io_recv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        instr_retire;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output io_trans, io_recv, addr, wdata, instr_retire, tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  io_trans, io_recv, addr, wdata, instr_retire, tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/io_mmio_unit.sv
// Memory-mapped I/O target: UART TX/RX FIFOs, sticky overflow status,
// cycle and retired-instruction counters, registered load data.
module io_mmio_unit #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    io_mmio_unit_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_PW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_PW = RX_AW + 1;

    localparam logic [7:0] REG_STATUS     = 8'h00;
    localparam logic [7:0] REG_RX_DATA    = 8'h04;
    localparam logic [7:0] REG_TX_DATA    = 8'h08;
    localparam logic [7:0] REG_STATUS_CLR = 8'h0C;
    localparam logic [7:0] REG_CYCLE_CNT  = 8'h10;
    localparam logic [7:0] REG_INSTR_CNT  = 8'h14;

    logic [7:0] regAddr;
    logic       anyWrite;
    logic       txWrite;
    logic       clrWrite;
    logic       cycWrite;
    logic       instrWrite;
    logic       rxRead;
    logic       unusedBits;

    assign regAddr    = bus.addr[7:0];
    assign anyWrite   = |bus.io_trans;
    assign txWrite    = bus.io_trans[0] && (regAddr == REG_TX_DATA);
    assign clrWrite   = anyWrite && (regAddr == REG_STATUS_CLR);
    assign cycWrite   = anyWrite && (regAddr == REG_CYCLE_CNT);
    assign instrWrite = anyWrite && (regAddr == REG_INSTR_CNT);
    assign rxRead     = bus.io_recv && (regAddr == REG_RX_DATA);
    assign unusedBits = ^{bus.addr[31:8], bus.wdata[31:8]};

    logic [7:0]       txMem [TX_DEPTH];
    logic [TX_PW-1:0] txWrPtr_q, txWrPtr_d;
    logic [TX_PW-1:0] txRdPtr_q, txRdPtr_d;
    logic             txEmpty, txFull, txPop, txPush, txOvfSet;

    logic [7:0]       rxMem [RX_DEPTH];
    logic [RX_PW-1:0] rxWrPtr_q, rxWrPtr_d;
    logic [RX_PW-1:0] rxRdPtr_q, rxRdPtr_d;
    logic             rxEmpty, rxFull, rxPop, rxPush, rxOvfSet;

    logic        txOvf_q, txOvf_d;
    logic        rxOvf_q, rxOvf_d;
    logic [31:0] cycleCnt_q, cycleCnt_d;
    logic [31:0] instrCnt_q, instrCnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] readData;

    assign txEmpty = (txWrPtr_q == txRdPtr_q);
    assign txFull  = (txWrPtr_q[TX_AW-1:0] == txRdPtr_q[TX_AW-1:0]) &&
                     (txWrPtr_q[TX_AW] != txRdPtr_q[TX_AW]);
    assign rxEmpty = (rxWrPtr_q == rxRdPtr_q);
    assign rxFull  = (rxWrPtr_q[RX_AW-1:0] == rxRdPtr_q[RX_AW-1:0]) &&
                     (rxWrPtr_q[RX_AW] != rxRdPtr_q[RX_AW]);

    // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
    assign txPop    = !txEmpty && bus.tx_ready;
    assign txPush   = txWrite && (!txFull || txPop);
    assign txOvfSet = txWrite && txFull && !txPop;

    assign rxPop    = rxRead && !rxEmpty;
    assign rxPush   = bus.rx_valid && !rxFull;
    assign rxOvfSet = bus.rx_valid && rxFull;

    assign bus.tx_data  = txMem[txRdPtr_q[TX_AW-1:0]];
    assign bus.tx_valid = !txEmpty;
    assign bus.rx_ready = !rxFull;
    assign bus.rdata    = rdata_q;

    always_comb begin
        txWrPtr_d = txWrPtr_q;
        txRdPtr_d = txRdPtr_q;
        rxWrPtr_d = rxWrPtr_q;
        rxRdPtr_d = rxRdPtr_q;
        if (txPush) txWrPtr_d = txWrPtr_q + TX_PW'(1);
        if (txPop)  txRdPtr_d = txRdPtr_q + TX_PW'(1);
        if (rxPush) rxWrPtr_d = rxWrPtr_q + RX_PW'(1);
        if (rxPop)  rxRdPtr_d = rxRdPtr_q + RX_PW'(1);
    end

    // An overflow in the same cycle as a clear is kept so the event is not lost.
    always_comb begin
        txOvf_d = txOvf_q;
        rxOvf_d = rxOvf_q;
        if (clrWrite) begin
            txOvf_d = 1'b0;
            rxOvf_d = 1'b0;
        end
        if (txOvfSet) txOvf_d = 1'b1;
        if (rxOvfSet) rxOvf_d = 1'b1;
    end

    always_comb begin
        cycleCnt_d = cycWrite ? 32'd0 : cycleCnt_q + 32'd1;
        instrCnt_d = instrWrite ? 32'd0 : instrCnt_q + {31'd0, bus.instr_retire};
    end

    // Counter reads return the post-update value, so a read right after a
    // zeroing write already shows one elapsed cycle.
    always_comb begin
        readData = 32'd0;
        case (regAddr)
            REG_STATUS:    readData = {28'd0, rxOvf_q, txOvf_q, !rxEmpty, !txFull};
            REG_RX_DATA:   if (!rxEmpty) readData = {24'd0, rxMem[rxRdPtr_q[RX_AW-1:0]]};
            REG_CYCLE_CNT: readData = cycleCnt_d;
            REG_INSTR_CNT: readData = instrCnt_d;
            default:       readData = 32'd0;
        endcase
        rdata_d = bus.io_recv ? readData : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (txPush) txMem[txWrPtr_q[TX_AW-1:0]] <= bus.wdata[7:0];
        if (rxPush) rxMem[rxWrPtr_q[RX_AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txWrPtr_q  <= '0;
            txRdPtr_q  <= '0;
            rxWrPtr_q  <= '0;
            rxRdPtr_q  <= '0;
            txOvf_q    <= 1'b0;
            rxOvf_q    <= 1'b0;
            cycleCnt_q <= 32'd0;
            instrCnt_q <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            txWrPtr_q  <= txWrPtr_d;
            txRdPtr_q  <= txRdPtr_d;
            rxWrPtr_q  <= rxWrPtr_d;
            rxRdPtr_q  <= rxRdPtr_d;
            txOvf_q    <= txOvf_d;
            rxOvf_q    <= rxOvf_d;
            cycleCnt_q <= cycleCnt_d;
            instrCnt_q <= instrCnt_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_io_mmio_unit.sv
// Bench for io_mmio_unit: directed scenarios plus random traffic, all checked
// against a queue-based model of the register map, FIFOs and counters.
module tb_io_mmio_unit;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_mmio_unit_if bus();

    io_mmio_unit #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  txQ[$];
    logic [7:0]  rxQ[$];
    logic        txOvf, rxOvf;
    logic [31:0] cycModel, instrModel, expRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] trans, input logic recv, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        bus.io_trans = trans;
        bus.io_recv  = recv;
        bus.addr     = addr;
        bus.wdata    = wdata;
    endtask

    task automatic resetModel();
        txQ.delete();
        rxQ.delete();
        txOvf      = 1'b0;
        rxOvf      = 1'b0;
        cycModel   = 32'd0;
        instrModel = 32'd0;
        expRdata   = 32'd0;
    endtask

    // Advance the model by one clock from the currently applied inputs, clock
    // the DUT, then compare all visible outputs on the following falling edge.
    task automatic runCycle();
        logic [7:0]  a;
        logic [31:0] readVal;
        logic [31:0] cycNext, instrNext;
        logic        recv, rxWasFull;
        a = bus.addr[7:0];
        recv = bus.io_recv;
        cycNext   = (bus.io_trans != 4'h0 && a == 8'h10) ? 32'd0 : cycModel + 32'd1;
        instrNext = (bus.io_trans != 4'h0 && a == 8'h14) ? 32'd0 : instrModel + (bus.instr_retire ? 32'd1 : 32'd0);
        readVal = 32'd0;
        case (a)
            8'h00: readVal = {28'd0, rxOvf, txOvf, rxQ.size() != 0, txQ.size() < TX_DEPTH};
            8'h04: if (rxQ.size() != 0) readVal = {24'd0, rxQ[0]};
            8'h10: readVal = cycNext;
            8'h14: readVal = instrNext;
            default: readVal = 32'd0;
        endcase
        if (bus.io_trans != 4'h0 && a == 8'h0C) begin
            txOvf = 1'b0;
            rxOvf = 1'b0;
        end
        if (txQ.size() != 0 && bus.tx_ready) void'(txQ.pop_front());
        if (bus.io_trans[0] && a == 8'h08) begin
            if (txQ.size() < TX_DEPTH) txQ.push_back(bus.wdata[7:0]);
            else txOvf = 1'b1;
        end
        rxWasFull = (rxQ.size() == RX_DEPTH);
        if (recv && a == 8'h04 && rxQ.size() != 0) void'(rxQ.pop_front());
        if (bus.rx_valid) begin
            if (rxWasFull) rxOvf = 1'b1;
            else rxQ.push_back(bus.rx_data);
        end
        cycModel   = cycNext;
        instrModel = instrNext;
        @(posedge clk);
        @(negedge clk);
        if (recv) expRdata = readVal;
        checkOutput("rdata", bus.rdata, expRdata);
        checkOutput("txValid", {31'd0, bus.tx_valid}, {31'd0, txQ.size() != 0});
        if (txQ.size() != 0) checkOutput("txData", {24'd0, bus.tx_data}, {24'd0, txQ[0]});
        checkOutput("rxReady", {31'd0, bus.rx_ready}, {31'd0, rxQ.size() < RX_DEPTH});
    endtask

    task automatic idleCycle();
        applyStimulus(4'h0, 1'b0, 32'h0, 32'h0);
        runCycle();
    endtask

    initial begin
        int op;
        rst_n = 1'b0;
        applyStimulus(4'h0, 1'b0, 32'h0, 32'h0);
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.instr_retire = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("resetTxValid", {31'd0, bus.tx_valid}, 32'd0);
        checkOutput("resetRxReady", {31'd0, bus.rx_ready}, 32'd1);
        checkOutput("resetRdata", bus.rdata, 32'd0);
        rst_n = 1'b1;

        // Single TX byte, then drained by one cycle of tx_ready.
        applyStimulus(4'h1, 1'b0, 32'h8000_0008, 32'h0000_0041);
        runCycle();
        checkOutput("firstTxData", {24'd0, bus.tx_data}, 32'h41);
        bus.tx_ready = 1'b1;
        idleCycle();
        checkOutput("firstTxDrained", {31'd0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;

        // TX overflow, in-order drain, sticky clear.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(4'h1, 1'b0, 32'h8000_0008, 32'(i));
            runCycle();
        end
        applyStimulus(4'h0, 1'b1, 32'h8000_0000, 32'h0);
        runCycle();
        checkOutput("statusTxOverflow", bus.rdata, 32'h4);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkOutput("txDrainOrder", {24'd0, bus.tx_data}, 32'(i));
            idleCycle();
        end
        bus.tx_ready = 1'b0;
        applyStimulus(4'hF, 1'b0, 32'h8000_000C, 32'h0);
        runCycle();
        applyStimulus(4'h0, 1'b1, 32'h8000_0000, 32'h0);
        runCycle();
        checkOutput("statusCleared", bus.rdata, 32'h1);

        // RX fill, overflow, ordered reads, empty read.
        for (int i = 0; i < 9; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(8'h10 + i);
            idleCycle();
        end
        bus.rx_valid = 1'b0;
        checkOutput("rxFullReady", {31'd0, bus.rx_ready}, 32'd0);
        applyStimulus(4'h0, 1'b1, 32'h8000_0000, 32'h0);
        runCycle();
        checkOutput("statusRxOverflow", bus.rdata, 32'hB);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'h0, 1'b1, 32'h8000_0004, 32'h0);
            runCycle();
            checkOutput("rxReadOrder", bus.rdata, (i < 8) ? 32'(8'h10 + i) : 32'd0);
        end

        // Counters: zero both, retire five instructions, read on the sixth cycle.
        applyStimulus(4'hF, 1'b0, 32'h8000_0014, 32'h0);
        runCycle();
        applyStimulus(4'hF, 1'b0, 32'h8000_0010, 32'h0);
        runCycle();
        bus.instr_retire = 1'b1;
        repeat (5) idleCycle();
        bus.instr_retire = 1'b0;
        applyStimulus(4'h0, 1'b1, 32'h8000_0010, 32'h0);
        runCycle();
        checkOutput("cycleElapsed", bus.rdata, 32'd6);
        applyStimulus(4'h0, 1'b1, 32'h8000_0014, 32'h0);
        runCycle();
        checkOutput("instrRetired", bus.rdata, 32'd5);

        // Counter wrap from a forced near-wrap value.
        force dut.cycleCnt_q = 32'hFFFF_FFFE;
        #1 release dut.cycleCnt_q;
        cycModel = 32'hFFFF_FFFE;
        idleCycle();
        applyStimulus(4'h0, 1'b1, 32'h8000_0010, 32'h0);
        runCycle();
        checkOutput("cycleWrap", bus.rdata, 32'd0);

        // Asynchronous reset in the middle of a TX drain.
        applyStimulus(4'h0, 1'b1, 32'h8000_0014, 32'h0);
        runCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h1, 1'b0, 32'h8000_0008, 32'(8'hA0 + i));
            runCycle();
        end
        bus.tx_ready = 1'b1;
        idleCycle();
        applyStimulus(4'h0, 1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1 checkOutput("txValidAsyncReset", {31'd0, bus.tx_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        checkOutput("rdataAfterReset", bus.rdata, 32'd0);
        applyStimulus(4'h0, 1'b1, 32'h8000_0000, 32'h0);
        runCycle();
        checkOutput("statusAfterReset", bus.rdata, 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 9);
            bus.tx_ready     = ($urandom_range(0, 2) == 0);
            bus.rx_valid     = ($urandom_range(0, 1) == 1);
            bus.rx_data      = 8'($urandom);
            bus.instr_retire = ($urandom_range(0, 1) == 1);
            case (op)
                0, 1, 2: applyStimulus(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h1,
                                       1'b0, {4'h8, 20'($urandom), 8'h08}, $urandom);
                3, 4:    applyStimulus(4'h0, 1'b1, {4'h8, 20'($urandom), 8'h04}, 32'h0);
                5:       applyStimulus(4'h0, 1'b1, 32'h8000_0000, 32'h0);
                6:       if ($urandom_range(0, 3) == 0) applyStimulus(4'hF, 1'b0, 32'h8000_000C, 32'h0);
                         else applyStimulus(4'h0, 1'b0, 32'h0, 32'h0);
                7:       applyStimulus(4'h0, 1'b1, ($urandom_range(0, 1) == 1) ? 32'h8000_0010 : 32'h8000_0014, 32'h0);
                8:       if ($urandom_range(0, 1) == 1)
                             applyStimulus(4'($urandom_range(1, 15)), 1'b0, {24'h800000, 8'($urandom_range(8'h18, 8'hFF))}, $urandom);
                         else
                             applyStimulus(4'h0, 1'b1, {24'h800000, 8'($urandom_range(8'h15, 8'hFF))}, 32'h0);
                default: applyStimulus(4'h0, 1'b0, 32'h0, 32'h0);
            endcase
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
